// File: rtl/systolic_skew_feeder.sv
// Operand skew front-end and tile sequencer for an n x n systolic MAC array.
// Build option FEEDER_STALL_EN: input bubbles freeze the array instead of injecting zeros.
module systolic_skew_feeder #(
    parameter int data_width = 8,
    parameter int n          = 2,
    parameter int skew       = 2,
    parameter int klen_width = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [klen_width-1:0]   k_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [n*data_width-1:0] s_a,
    input  logic [n*data_width-1:0] s_b,
    output logic [n*data_width-1:0] arr_a,
    output logic [n*data_width-1:0] arr_b,
    output logic                    arr_en,
    output logic                    arr_rst,
    output logic                    busy,
    output logic                    done
);

    // Long enough for the last operand pair to traverse the array corner to corner.
    localparam int flush_len = skew * (2 * n - 2) + 4;
    localparam int flush_w   = $clog2(flush_len + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [klen_width-1:0]   klen_reg;
    logic [klen_width-1:0]   beat_cnt_reg;
    logic [flush_w-1:0]      flush_cnt_reg;
    logic [n*data_width-1:0] stage0_a_reg;
    logic [n*data_width-1:0] stage0_b_reg;
    logic                    accept;
    logic                    last_beat;
    logic                    advance;
    logic                    clear_chains;

    assign accept       = (state_reg == STREAM) && s_valid;
    assign last_beat    = accept && (beat_cnt_reg == klen_reg - klen_width'(1));
    assign clear_chains = (state_reg == CLEAR);

`ifdef FEEDER_STALL_EN
    assign advance = accept || (state_reg == FLUSH);
`else
    assign advance = (state_reg == STREAM) || (state_reg == FLUSH);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = (klen_reg != '0) ? STREAM : FLUSH;
            STREAM:  if (last_beat) state_next = FLUSH;
            FLUSH:   if (flush_cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            klen_reg      <= '0;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                klen_reg     <= k_len;
                beat_cnt_reg <= '0;
            end else if (accept && beat_cnt_reg != klen_reg) begin
                beat_cnt_reg <= beat_cnt_reg + klen_width'(1);
            end
            if (state_reg != FLUSH && state_next == FLUSH) begin
                flush_cnt_reg <= flush_w'(flush_len - 1);
            end else if (state_reg == FLUSH && flush_cnt_reg != '0) begin
                flush_cnt_reg <= flush_cnt_reg - flush_w'(1);
            end
        end
    end

    // Stage 0 captures the whole beat; bubbles and flush cycles load zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage0_a_reg <= '0;
            stage0_b_reg <= '0;
        end else if (clear_chains) begin
            stage0_a_reg <= '0;
            stage0_b_reg <= '0;
        end else if (advance) begin
            stage0_a_reg <= accept ? s_a : '0;
            stage0_b_reg <= accept ? s_b : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_lane
            if (gi == 0 || skew == 0) begin : g_direct
                assign arr_a[gi*data_width +: data_width] = stage0_a_reg[gi*data_width +: data_width];
                assign arr_b[gi*data_width +: data_width] = stage0_b_reg[gi*data_width +: data_width];
            end else begin : g_chain
                localparam int depth = skew * gi;
                logic [data_width-1:0] a_sr [depth];
                logic [data_width-1:0] b_sr [depth];

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int k = 0; k < depth; k++) begin
                            a_sr[k] <= '0;
                            b_sr[k] <= '0;
                        end
                    end else if (clear_chains) begin
                        for (int k = 0; k < depth; k++) begin
                            a_sr[k] <= '0;
                            b_sr[k] <= '0;
                        end
                    end else if (advance) begin
                        a_sr[0] <= stage0_a_reg[gi*data_width +: data_width];
                        b_sr[0] <= stage0_b_reg[gi*data_width +: data_width];
                        for (int k = 1; k < depth; k++) begin
                            a_sr[k] <= a_sr[k-1];
                            b_sr[k] <= b_sr[k-1];
                        end
                    end
                end

                assign arr_a[gi*data_width +: data_width] = a_sr[depth-1];
                assign arr_b[gi*data_width +: data_width] = b_sr[depth-1];
            end
        end
    endgenerate

    assign s_ready = (state_reg == STREAM);
    assign arr_en  = advance;
    assign arr_rst = (state_reg == CLEAR);
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: drives tiles into the feeder, models the MAC array
// behind it, and compares the array's results with a plain matrix product.
module tb_systolic_skew_feeder;

    localparam int DW = 8;
    localparam int N  = 2;
    localparam int SK = 2;
    localparam int KW = 16;
    localparam int F  = SK * (2 * N - 2) + 4;
    localparam int KMAX = 8;
`ifdef FEEDER_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [N*DW-1:0] s_a = '0;
    logic [N*DW-1:0] s_b = '0;
    logic [N*DW-1:0] arr_a;
    logic [N*DW-1:0] arr_b;
    logic          arr_en;
    logic          arr_rst;
    logic          busy;
    logic          done;

    systolic_skew_feeder #(.data_width(DW), .n(N), .skew(SK), .klen_width(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .arr_a(arr_a), .arr_b(arr_b), .arr_en(arr_en), .arr_rst(arr_rst),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Operands and bench-side expectations.
    logic [DW-1:0] mat_a [N][KMAX];
    logic [DW-1:0] mat_b [KMAX][N];
    int            gaps [KMAX];
    int            exp_c [N][N];

    // Behavioural N x N MAC array fed from the feeder's edges.
    logic [N*DW-1:0] sm_a, sm_b;
    logic            sm_en, sm_rst;
    int              acc [N][N];
    logic [DW-1:0]   ap [N][N][SK];
    logic [DW-1:0]   bp [N][N][SK];
    logic [N*DW-1:0] tr_a [4096];
    logic [N*DW-1:0] tr_b [4096];

    always @(negedge clk) begin
        sm_a   <= arr_a;
        sm_b   <= arr_b;
        sm_en  <= arr_en;
        sm_rst <= arr_rst;
        if (cyc < 4096) begin
            tr_a[cyc] <= arr_a;
            tr_b[cyc] <= arr_b;
        end
    end

    function automatic logic [DW-1:0] a_in(input int i, input int j);
        if (j == 0) return sm_a[i*DW +: DW];
        return ap[i][j-1][SK-1];
    endfunction

    function automatic logic [DW-1:0] b_in(input int i, input int j);
        if (i == 0) return sm_b[j*DW +: DW];
        return bp[i-1][j][SK-1];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (sm_rst) begin
                    acc[i][j] <= 0;
                    for (int k = 0; k < SK; k++) begin
                        ap[i][j][k] <= '0;
                        bp[i][j][k] <= '0;
                    end
                end else if (sm_en) begin
                    acc[i][j]   <= acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
                    ap[i][j][0] <= a_in(i, j);
                    bp[i][j][0] <= b_in(i, j);
                    for (int k = 1; k < SK; k++) begin
                        ap[i][j][k] <= ap[i][j][k-1];
                        bp[i][j][k] <= bp[i][j][k-1];
                    end
                end
            end
        end
    end

    function automatic logic [N*DW-1:0] pack_a(input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = mat_a[i][k];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pack_b(input int k);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = mat_b[k][j];
        return v;
    endfunction

    task automatic compute_expected(input int klen);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < klen; k++)
                    exp_c[i][j] += int'(mat_a[i][k]) * int'(mat_b[k][j]);
            end
    endtask

    task automatic load_basic();
        mat_a[0][0] = 8'd1; mat_a[0][1] = 8'd2;
        mat_a[1][0] = 8'd3; mat_a[1][1] = 8'd4;
        mat_b[0][0] = 8'd5; mat_b[0][1] = 8'd6;
        mat_b[1][0] = 8'd7; mat_b[1][1] = 8'd8;
        for (int k = 0; k < KMAX; k++) gaps[k] = 0;
    endtask

    // Observations gathered while a tile runs.
    int dones, ready_cnt, en_low, flush_cyc, rst_cnt, bub_cnt, extra_dones;
    int done_cycle, last_acc, first_ready, start_cycle;
    logic busy_after;
    int got_c [N][N];

    task automatic drive_tile(input int klen, input bit pulse_start);
        int k;
        int gap;
        int n_cyc;
        k = 0; gap = gaps[0]; n_cyc = 0;
        dones = 0; ready_cnt = 0; en_low = 0; flush_cyc = 0; rst_cnt = 0; bub_cnt = 0;
        extra_dones = 0; done_cycle = -1; last_acc = -1; first_ready = -1;
        busy_after = 1'b1;
        k_len = KW'(klen);
        start = 1'b1;
        s_valid = 1'b0;
        start_cycle = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (dones == 0 && n_cyc < 400) begin
            if (k < klen && gap == 0) begin
                s_valid = 1'b1;
                s_a = pack_a(k);
                s_b = pack_b(k);
            end else begin
                s_valid = 1'b0;
                s_a = (N*DW)'($urandom);
                s_b = (N*DW)'($urandom);
            end
            start = pulse_start && busy && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (s_ready) begin
                ready_cnt++;
                if (first_ready < 0) first_ready = cyc;
            end
            if (s_ready && !arr_en) en_low++;
            if (s_ready && !s_valid) begin
                bub_cnt++;
                if (gap > 0) gap--;
            end
            if (busy && !s_ready && arr_en) flush_cyc++;
            if (arr_rst) rst_cnt++;
            if (s_valid && s_ready) begin
                last_acc = cyc;
                k++;
                if (k < klen) gap = gaps[k];
            end
            if (done) begin
                dones++;
                done_cycle = cyc;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) got_c[i][j] = acc[i][j];
            end
            @(posedge clk); #1;
            n_cyc++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        busy_after = busy;
        for (int i = 0; i < 5; i++) begin
            if (done) extra_dones++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        checks++; if (arr_a !== '0) begin errors++; $display("FAIL reset_arr_a: got %h expected 0", arr_a); end
        checks++; if (arr_b !== '0) begin errors++; $display("FAIL reset_arr_b: got %h expected 0", arr_b); end
        checks++; if (arr_en !== 1'b0) begin errors++; $display("FAIL reset_arr_en: got %b expected 0", arr_en); end
        checks++; if (arr_rst !== 1'b0) begin errors++; $display("FAIL reset_arr_rst: got %b expected 0", arr_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        $display("reset: released");
    endtask

    task automatic test_basic();
        load_basic();
        compute_expected(2);
        drive_tile(2, 1'b0);
        checks++; if (dones !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dones); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_c[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL basic_c[%0d][%0d]: got %0d expected %0d", i, j, got_c[i][j], exp_c[i][j]);
                end
            end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
        checks++; if (done_cycle - last_acc !== F + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", done_cycle - last_acc, F + 1); end
        checks++; if (first_ready - start_cycle !== 2) begin errors++; $display("FAIL basic_first_ready: got %0d expected 2", first_ready - start_cycle); end
        checks++; if (rst_cnt !== 1) begin errors++; $display("FAIL basic_arr_rst_cycles: got %0d expected 1", rst_cnt); end
        checks++; if (flush_cyc !== F) begin errors++; $display("FAIL basic_flush_cycles: got %0d expected %0d", flush_cyc, F); end
        checks++; if (ready_cnt !== 2) begin errors++; $display("FAIL basic_ready_cycles: got %0d expected 2", ready_cnt); end
        checks++; if (extra_dones !== 0) begin errors++; $display("FAIL basic_extra_done: got %0d expected 0", extra_dones); end
        $display("basic: C=[[%0d,%0d],[%0d,%0d]] latency=%0d", got_c[0][0], got_c[0][1], got_c[1][0], got_c[1][1], done_cycle - last_acc);
    endtask

    task automatic test_skew();
        int c;
        load_basic();
        mat_a[0][0] = 8'h11; mat_a[1][0] = 8'h22;
        mat_b[0][0] = 8'h33; mat_b[0][1] = 8'h44;
        compute_expected(1);
        drive_tile(1, 1'b0);
        c = (last_acc < 0) ? 0 : last_acc;
        checks++; if (tr_a[c+1][7:0] !== 8'h11) begin errors++; $display("FAIL skew_a_lane0: got %h expected 11", tr_a[c+1][7:0]); end
        checks++; if (tr_a[c+2][15:8] !== 8'h00) begin errors++; $display("FAIL skew_a_lane1_early: got %h expected 00", tr_a[c+2][15:8]); end
        checks++; if (tr_a[c+3][15:8] !== 8'h22) begin errors++; $display("FAIL skew_a_lane1: got %h expected 22", tr_a[c+3][15:8]); end
        checks++; if (tr_b[c+1][7:0] !== 8'h33) begin errors++; $display("FAIL skew_b_lane0: got %h expected 33", tr_b[c+1][7:0]); end
        checks++; if (tr_b[c+3][15:8] !== 8'h44) begin errors++; $display("FAIL skew_b_lane1: got %h expected 44", tr_b[c+3][15:8]); end
        checks++; if (tr_a[c+2][7:0] !== 8'h00) begin errors++; $display("FAIL skew_a_lane0_after: got %h expected 00", tr_a[c+2][7:0]); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_c[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL skew_c[%0d][%0d]: got %0d expected %0d", i, j, got_c[i][j], exp_c[i][j]);
                end
            end
        $display("skew: beat at cycle %0d, lane0=%h lane1=%h", c, tr_a[c+1][7:0], tr_a[c+3][15:8]);
    endtask

    task automatic test_bubbles();
        int exp_low;
        load_basic();
        gaps[1] = 3;
        compute_expected(2);
        drive_tile(2, 1'b0);
        exp_low = STALL ? 3 : 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_c[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL bubble_c[%0d][%0d]: got %0d expected %0d", i, j, got_c[i][j], exp_c[i][j]);
                end
            end
        checks++; if (en_low !== exp_low) begin errors++; $display("FAIL bubble_en_low: got %0d expected %0d", en_low, exp_low); end
        checks++; if (ready_cnt !== 5) begin errors++; $display("FAIL bubble_ready_cycles: got %0d expected 5", ready_cnt); end
        checks++; if (done_cycle - last_acc !== F + 1) begin errors++; $display("FAIL bubble_latency: got %0d expected %0d", done_cycle - last_acc, F + 1); end
        $display("bubbles: en_low=%0d ready=%0d C00=%0d", en_low, ready_cnt, got_c[0][0]);
    endtask

    task automatic test_zero_len();
        load_basic();
        drive_tile(0, 1'b0);
        checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL zero_s_ready: got %0d cycles expected 0", ready_cnt); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", dones); end
        checks++; if (done_cycle - start_cycle !== F + 2) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", done_cycle - start_cycle, F + 2); end
        checks++; if (flush_cyc !== F) begin errors++; $display("FAIL zero_flush_cycles: got %0d expected %0d", flush_cyc, F); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_c[i][j] !== 0) begin
                    errors++;
                    $display("FAIL zero_c[%0d][%0d]: got %0d expected 0", i, j, got_c[i][j]);
                end
            end
        $display("zero_len: done after %0d cycles", done_cycle - start_cycle);
    endtask

    task automatic test_reset_mid();
        int w;
        load_basic();
        k_len = KW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_a = pack_a(0);
        s_b = pack_b(0);
        w = 0;
        @(negedge clk);
        while (!s_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_wait_ready: got %b expected 1", s_ready); end
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready: got %b expected 0", s_ready); end
        checks++; if (arr_a !== '0) begin errors++; $display("FAIL midrst_arr_a: got %h expected 0", arr_a); end
        checks++; if (arr_b !== '0) begin errors++; $display("FAIL midrst_arr_b: got %h expected 0", arr_b); end
        checks++; if (arr_en !== 1'b0) begin errors++; $display("FAIL midrst_arr_en: got %b expected 0", arr_en); end
        checks++; if (arr_rst !== 1'b0) begin errors++; $display("FAIL midrst_arr_rst: got %b expected 0", arr_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        compute_expected(2);
        drive_tile(2, 1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_c[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL midrst_c[%0d][%0d]: got %0d expected %0d", i, j, got_c[i][j], exp_c[i][j]);
                end
            end
        $display("reset_mid: retile C=[[%0d,%0d],[%0d,%0d]]", got_c[0][0], got_c[0][1], got_c[1][0], got_c[1][1]);
    endtask

    task automatic test_ignored_start();
        load_basic();
        compute_expected(2);
        drive_tile(2, 1'b1);
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignstart_done_count: got %0d expected 1", dones); end
        checks++; if (extra_dones !== 0) begin errors++; $display("FAIL ignstart_extra_done: got %0d expected 0", extra_dones); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ignstart_busy_after: got %b expected 0", busy_after); end
        checks++; if (done_cycle - last_acc !== F + 1) begin errors++; $display("FAIL ignstart_latency: got %0d expected %0d", done_cycle - last_acc, F + 1); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_c[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL ignstart_c[%0d][%0d]: got %0d expected %0d", i, j, got_c[i][j], exp_c[i][j]);
                end
            end
        $display("ignored_start: dones=%0d extra=%0d", dones, extra_dones);
    endtask

    task automatic test_random();
        int klen;
        int exp_low;
        for (int t = 0; t < 6; t++) begin
            klen = $urandom_range(1, 6);
            for (int k = 0; k < KMAX; k++) begin
                gaps[k] = $urandom_range(0, 2);
                for (int i = 0; i < N; i++) begin
                    mat_a[i][k] = DW'($urandom);
                    mat_b[k][i] = DW'($urandom);
                end
            end
            compute_expected(klen);
            drive_tile(klen, t[0]);
            exp_low = STALL ? bub_cnt : 0;
            checks++; if (dones !== 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d expected 1", t, dones); end
            checks++; if (done_cycle - last_acc !== F + 1) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, done_cycle - last_acc, F + 1); end
            checks++; if (en_low !== exp_low) begin errors++; $display("FAIL rand%0d_en_low: got %0d expected %0d", t, en_low, exp_low); end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (got_c[i][j] !== exp_c[i][j]) begin
                        errors++;
                        $display("FAIL rand%0d_c[%0d][%0d]: got %0d expected %0d", t, i, j, got_c[i][j], exp_c[i][j]);
                    end
                end
            $display("random tile %0d: k_len=%0d bubbles=%0d C=[[%0d,%0d],[%0d,%0d]]",
                     t, klen, bub_cnt, got_c[0][0], got_c[0][1], got_c[1][0], got_c[1][1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_bubbles();
        test_zero_len();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Front-end stage for the N×N systolic MAC array: accepts one operand beat per cycle (column k of A, row k of B) over a valid/ready handshake and drives the array's west (a) and north (b) edge inputs with per-lane staggering, so operands meet at each PE on the same cycle. It sequences one tile: it clears the accumulators, streams `k_len` beats, flushes zeros until every PE's `c_out` is final, then pulses `done`. The array's `en` and `rst` inputs are driven from this block.

## Interface
- `data_width`, 8: operand width per lane.
- `n`, 2: array dimension, which is also the number of a lanes and b lanes.
- `skew`, 2: per-hop operand latency of a PE in cycles. Lane i is delayed by `skew*i`.
- `klen_width`, 16: width of `k_len` and of the beat counter.

- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-low reset (asserted at 0).
- `start`, in, 1: begins a tile; sampled only in IDLE.
- `k_len`, in, `klen_width`: number of beats in the tile; latched when `start` is accepted.
- `s_valid`, in, 1: operand beat valid.
- `s_ready`, out, 1: beat accepted when `s_valid && s_ready`.
- `s_a`, in, `n*data_width`: A column; lane i at bits [i*data_width +: data_width].
- `s_b`, in, `n*data_width`: B row; same lane packing as `s_a`.
- `arr_a`, out, `n*data_width`: skewed a lanes to the array's west edge.
- `arr_b`, out, `n*data_width`: skewed b lanes to the array's north edge.
- `arr_en`, out, 1: array enable.
- `arr_rst`, out, 1: active-high accumulator clear; drives the PE `rst` pin.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse; all PE `c_out` values are final and stable.

## Operation
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
- **IDLE:** `start` latches `k_len` and moves to CLEAR. `start` in any other state is ignored.
- **CLEAR:** `arr_rst`=1 for exactly one cycle, and all skew registers are zeroed.
  - `k_len`≠0: go to STREAM.
  - `k_len`=0: go to FLUSH.
- **STREAM:** `s_ready`=1.
  - Each accepted beat enters lane-0 stage 0 and increments the beat counter.
  - The cycle that accepts beat `k_len`-1 moves the FSM to FLUSH.
- **FLUSH:** `s_ready`=0 and zeros are injected into all lanes with `arr_en`=1. It lasts F = `skew*(2n-2)+4` cycles, counted by a down-counter, then moves to DONE.
- **DONE:** `done`=1 and `arr_en`=0 for one cycle, then return to IDLE.
- **Skew structure:** lane i is a shift chain of `skew*i` registers. Lane 0 is combinational from the stage-0 register. All chains advance together only when the array advances.
- **Arithmetic:** the block does no arithmetic on operands; data passes bit-exact. The beat counter saturates at `k_len`, so there is no wrap-around.
- **Reset mid-tile:**
  - FSM returns to IDLE; all registers and outputs are cleared.
  - `arr_rst` is 0 after reset. The next tile's CLEAR clears the accumulators.

## Timing
- **Reset values:**
  - `s_ready`, `arr_a`, `arr_b`, `arr_en`, `arr_rst`, `busy`, `done` are all 0.
  - FSM is in IDLE; all counters are 0.
- **Start to first beat:** `start` at cycle t gives CLEAR at t+1 and `s_ready`=1 at t+2.
- **Lane delay:** a beat accepted at cycle c appears on lane i of `arr_a`/`arr_b` at c+1+`skew*i`.
- **Tile latency:** from the last accepted beat to `done` is F+1 cycles when there are no stalls.
- **Input bubbles** (`s_valid`=0 during STREAM) depend on the build; see Configuration. The beat counter does not advance on a bubble.
- **`s_ready` timing:** `s_ready` is a registered state decode and does not depend on `s_valid`. It falls on the cycle after the last beat is accepted.

## Configuration
- `FEEDER_STALL_EN` defined:
  - On a bubble, `arr_en`=0 and all skew chains hold.
  - The array freezes, so total cycles = `k_len` + bubbles + F + overhead.
- `FEEDER_STALL_EN` undefined:
  - On a bubble, zeros are injected into stage 0 with `arr_en`=1.
  - Zero products leave the accumulations unchanged. Same results, with a simpler enable path.

## Test plan
- **Basic tile:** n=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], `k_len`=2, beats back-to-back -> `done` asserts with the array's C=[[19,22],[43,50]] and `busy` low the cycle after.
- **Skew check:** one beat `s_a`={lane1=0x22, lane0=0x11} accepted at cycle c -> `arr_a` lane0=0x11 at c+1 and lane1=0x22 at c+3 (`skew`=2).
- **Bubbles:** the basic tile with `s_valid` low for 3 cycles between the two beats -> same C in both builds. With `FEEDER_STALL_EN`, `arr_en` is low for exactly those 3 cycles.
- **Zero length:** `k_len`=0 -> CLEAR, then F FLUSH cycles, then a `done` pulse; all C=0; `s_ready` never high.
- **Reset mid-stream:** assert `rst`=0 after 1 of 2 beats -> all outputs 0 at once. The next full tile with the basic operands returns C=[[19,22],[43,50]], with no stale accumulation.
- **Ignored start:** `start` pulsed during STREAM and FLUSH -> no state change and exactly one `done` per tile.
